// File: rtl/psum_tile_accumulator_if.sv
// Bus bundle for psum_tile_accumulator: job config, tile input stream,
// result handshake and status/debug outputs.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. The source holds valid and data stable until that edge,
// and valid is never made to depend on ready. On the tile stream,
// tile_valid/tile_ready are that pair. On the result side, act_load acts
// as valid and act_ack as ready: act_load and act_out stay frozen until
// the edge that samples act_ack high.
interface psum_tile_accumulator_if #(
  parameter int WIDTH           = 16,
  parameter int LANES           = 16,
  parameter int MAX_INPUT_TILES = 8,
  parameter int QUEUE_DEPTH     = 4,
  parameter int SAT_OUT         = 0
);
  localparam int ACC_W = WIDTH + $clog2(MAX_INPUT_TILES);
  localparam int CNT_W = $clog2(MAX_INPUT_TILES + 1);
  localparam int OUT_W = (SAT_OUT != 0) ? WIDTH : ACC_W;
  localparam int QC_W  = $clog2(QUEUE_DEPTH) + 1;

  logic                            cfg_valid;
  logic [CNT_W-1:0]                num_input_tiles;
  logic                            tile_valid;
  logic                            tile_ready;
  logic [LANES-1:0][WIDTH-1:0]     tile_data;
  logic                            act_load;
  logic                            act_ack;
  logic [LANES-1:0][OUT_W-1:0]     act_out;
  logic                            busy;
  logic [QC_W-1:0]                 queue_count;
  // FSM state for checkers: 0 IDLE, 1 ACCUM, 2 DONE
  logic [1:0]                      state_dbg;

  modport master (
    output cfg_valid, num_input_tiles, tile_valid, tile_data, act_ack,
    input  tile_ready, act_load, act_out, busy, queue_count, state_dbg
  );

  modport slave (
    input  cfg_valid, num_input_tiles, tile_valid, tile_data, act_ack,
    output tile_ready, act_load, act_out, busy, queue_count, state_dbg
  );
endinterface

// File: rtl/psum_tile_accumulator.sv
// Partial-sum tile accumulator. Tiles of LANES signed WIDTH-bit values are
// queued in a small FIFO; a job sums a configured number of tiles lane-wise
// into ACC_W-bit accumulators and presents the result until acknowledged.
// QUEUE_DEPTH must be a power of two (>=2) so the pointers wrap naturally;
// MAX_INPUT_TILES must be >=1.
module psum_tile_accumulator #(
  parameter int WIDTH           = 16,
  parameter int LANES           = 16,
  parameter int MAX_INPUT_TILES = 8,
  parameter int QUEUE_DEPTH     = 4,
  parameter int SAT_OUT         = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  psum_tile_accumulator_if.slave   bus
);
  localparam int ACC_W = WIDTH + $clog2(MAX_INPUT_TILES);
  localparam int CNT_W = $clog2(MAX_INPUT_TILES + 1);
  localparam int OUT_W = (SAT_OUT != 0) ? WIDTH : ACC_W;
  localparam int QC_W  = $clog2(QUEUE_DEPTH) + 1;
  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;

  // FIFO storage and bookkeeping
  logic [LANES-1:0][WIDTH-1:0]   r_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]              r_wr_ptr;
  logic [PTR_W-1:0]              r_rd_ptr;
  logic [QC_W-1:0]               r_count;

  // Job bookkeeping and datapath
  logic [CNT_W-1:0]              r_target;
  logic [CNT_W-1:0]              r_cnt;
  logic [LANES-1:0][ACC_W-1:0]   r_acc;
  logic                          r_act_load;

  logic                          w_tile_ready;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_start;
  logic                          w_last_pop;
  logic                          w_ack;
  logic [CNT_W-1:0]              w_target_clamped;
  logic [CNT_W-1:0]              w_cnt_inc;
  logic [LANES-1:0][ACC_W-1:0]   w_pop_ext;
  logic [LANES-1:0][ACC_W-1:0]   w_acc_next;
  logic [LANES-1:0][OUT_W-1:0]   w_act_out;

  // Full FIFO never accepts, even if a pop happens in the same cycle.
  assign w_tile_ready = (r_count < QC_W'(QUEUE_DEPTH));
  assign w_push       = bus.tile_valid && w_tile_ready;
  // Tiles are consumed only while a job is accumulating.
  assign w_pop        = (r_state == S_ACCUM) && (r_count != '0);
  assign w_start      = (r_state == S_IDLE) && bus.cfg_valid &&
                        (bus.num_input_tiles != '0);
  assign w_cnt_inc    = r_cnt + CNT_W'(1);
  assign w_last_pop   = w_pop && (w_cnt_inc == r_target);
  assign w_ack        = (r_state == S_DONE) && bus.act_ack;

  assign w_target_clamped = (bus.num_input_tiles > CNT_W'(MAX_INPUT_TILES)) ?
                            CNT_W'(MAX_INPUT_TILES) : bus.num_input_tiles;

  // Next-state logic for the job sequencer
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start)    w_state_next = S_ACCUM;
      S_ACCUM: if (w_last_pop) w_state_next = S_DONE;
      S_DONE:  if (bus.act_ack) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + QC_W'(1);
        2'b01:   r_count <= r_count - QC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.tile_data;
  end

  // Head tile sign-extended; the first tile of a job replaces old sums
  always_comb begin
    w_pop_ext  = '0;
    w_acc_next = '0;
    for (int l = 0; l < LANES; l++) begin
      w_pop_ext[l]  = ACC_W'(signed'(r_mem[r_rd_ptr][l]));
      w_acc_next[l] = (r_cnt == '0) ? w_pop_ext[l] : (r_acc[l] + w_pop_ext[l]);
    end
  end

  // Job target, tile counter, accumulators and result-valid flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_target   <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_act_load <= 1'b0;
    end else begin
      if (w_start) begin
        r_target <= w_target_clamped;
        r_cnt    <= '0;
      end
      if (w_pop) begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_inc;
      end
      if (w_last_pop) begin
        r_act_load <= 1'b1;
      end else if (w_ack) begin
        r_act_load <= 1'b0;
      end
    end
  end

  generate
    if (SAT_OUT != 0) begin : g_sat
      localparam logic signed [ACC_W-1:0] SAT_MAX =
        ACC_W'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
      localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

      // Clamp each lane into the signed WIDTH range
      always_comb begin
        w_act_out = '0;
        for (int l = 0; l < LANES; l++) begin
          if ($signed(r_acc[l]) > SAT_MAX) begin
            w_act_out[l] = OUT_W'(SAT_MAX);
          end else if ($signed(r_acc[l]) < SAT_MIN) begin
            w_act_out[l] = OUT_W'(SAT_MIN);
          end else begin
            w_act_out[l] = OUT_W'(r_acc[l]);
          end
        end
      end
    end else begin : g_full
      // Full-width lanes pass straight through
      always_comb begin
        w_act_out = '0;
        for (int l = 0; l < LANES; l++) begin
          w_act_out[l] = OUT_W'(r_acc[l]);
        end
      end
    end
  endgenerate

  assign bus.tile_ready  = w_tile_ready;
  assign bus.act_load    = r_act_load;
  assign bus.act_out     = w_act_out;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.queue_count = r_count;
  assign bus.state_dbg   = r_state;
endmodule
